// File: rtl/alu_multicycle_ctrl.sv
// Issue/sequencing controller in front of the shared ALU: single-cycle codes go through
// the external ALU, DIV runs on an internal restoring divider. Optional MOD via `ALU_MOD_EN.
module alu_multicycle_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   ALUControl,
    input  logic [N-1:0] srcA,
    input  logic [N-1:0] srcB,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] resultado,
    output logic         div_zero,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [N:0]    rem_reg;
    logic [N-1:0]  quo_reg;
    logic [N-1:0]  divisor_reg;
    logic          is_mod_reg;
    logic [N-1:0]  alu_a_reg, alu_b_reg, resultado_reg;
    logic [3:0]    alu_ctrl_reg;
    logic          div_zero_reg;

    logic          accept;
    logic          is_div_code, is_mod_code;
    logic [3:0]    ctrl_eff;
    logic [N:0]    rem_shift, rem_step;
    logic [N-1:0]  quo_step;

    assign accept = op_valid && op_ready;

    // Unlisted codes fall back to ADD so the ALU mux never sees an undefined select.
    always_comb begin
        is_div_code = (ALUControl == 4'b0011);
`ifdef ALU_MOD_EN
        is_mod_code = (ALUControl == 4'b1010);
`else
        is_mod_code = 1'b0;
`endif
        ctrl_eff = ((ALUControl <= 4'b1001) || is_mod_code) ? ALUControl : 4'b0000;
    end

    // One restoring step; a zero divisor always subtracts, leaving quotient all ones
    // and the dividend in the remainder.
    always_comb begin
        rem_shift = (rem_reg << 1) | {{N{1'b0}}, quo_reg[N-1]};
        if (rem_shift >= {1'b0, divisor_reg}) begin
            rem_step = rem_shift - {1'b0, divisor_reg};
            quo_step = {quo_reg[N-2:0], 1'b1};
        end else begin
            rem_step = rem_shift;
            quo_step = {quo_reg[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (is_div_code || is_mod_code) ? DIV : EXEC;
            EXEC: state_next = DONE;
            DIV:  if (count_reg == CW'(1)) state_next = DONE;
            DONE: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_reg == IDLE);
        res_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_ctrl_reg  <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            divisor_reg   <= '0;
            count_reg     <= '0;
            is_mod_reg    <= 1'b0;
            resultado_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_reg    <= srcA;
                alu_b_reg    <= srcB;
                alu_ctrl_reg <= ctrl_eff;
                rem_reg      <= '0;
                quo_reg      <= srcA;
                divisor_reg  <= srcB;
                count_reg    <= CW'(N);
                is_mod_reg   <= is_mod_code;
            end
            case (state_reg)
                EXEC: begin
                    resultado_reg <= alu_result;
                    div_zero_reg  <= 1'b0;
                end
                DIV: begin
                    rem_reg   <= rem_step;
                    quo_reg   <= quo_step;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        resultado_reg <= is_mod_reg ? rem_step[N-1:0] : quo_step;
                        div_zero_reg  <= (divisor_reg == '0);
                    end
                end
                DONE: if (res_ready) div_zero_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_ctrl  = alu_ctrl_reg;
    assign resultado = resultado_reg;
    assign div_zero  = div_zero_reg;
endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Scoreboard bench for alu_multicycle_ctrl: expectations queued at accept, compared at res_valid.
module tb_alu_multicycle_ctrl;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid, op_ready;
    logic [3:0]   ALUControl;
    logic [N-1:0] srcA, srcB;
    logic [N-1:0] alu_a, alu_b, alu_result, resultado;
    logic [3:0]   alu_ctrl;
    logic         res_valid, res_ready, div_zero, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] res;
        logic         dz;
        int           lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_multicycle_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .ALUControl(ALUControl), .srcA(srcA), .srcB(srcB),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .resultado(resultado), .div_zero(div_zero), .busy(busy)
    );

    // Shared combinational ALU; DIV and undefined selects return a marker value.
    function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [3:0] c);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            4'd6: return a & b;
            4'd7: return a | b;
            4'd8: return a ^ b;
            4'd9: return ~a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_ctrl);

    function automatic exp_t ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [3:0] c);
        exp_t e;
        e.dz  = 1'b0;
        e.lat = 2;
        e.res = a + b;
        case (c)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = a * b;
            4'd3: begin
                e.lat = N + 1;
                if (b == 0) begin e.res = '1; e.dz = 1'b1; end
                else e.res = a / b;
            end
            4'd4: e.res = a << b[4:0];
            4'd5: e.res = a >> b[4:0];
            4'd6: e.res = a & b;
            4'd7: e.res = a | b;
            4'd8: e.res = a ^ b;
            4'd9: e.res = ~a;
`ifdef ALU_MOD_EN
            4'd10: begin
                e.lat = N + 1;
                if (b == 0) begin e.res = a; e.dz = 1'b1; end
                else e.res = a % b;
            end
`endif
            default: e.res = a + b;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] exp_ctrl(input logic [3:0] c);
        if (c <= 4'd9) return c;
`ifdef ALU_MOD_EN
        if (c == 4'd10) return c;
`endif
        return 4'd0;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive an op, wait for op_ready, return just after the accept edge.
    task automatic do_accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c);
        int w = 0;
        @(negedge clk);
        srcA = a; srcB = b; ALUControl = c; op_valid = 1'b1;
        while (!op_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_val("accept_ready", op_ready, 1);
        sb.push_back(ref_model(a, b, c));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check_val("alu_a", alu_a, a);
        check_val("alu_b", alu_b, b);
        check_val("alu_ctrl", alu_ctrl, exp_ctrl(c));
        check_val("busy", busy, 1);
    endtask

    // Called just after the accept edge; early_rdy holds res_ready high before res_valid.
    task automatic collect(input bit consume, input bit early_rdy);
        int   lat = 1;
        exp_t e;
        res_ready = early_rdy;
        while (!res_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("res_valid", res_valid, 1);
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_val("latency", lat, e.lat);
            check_val("resultado", resultado, e.res);
            check_val("div_zero", div_zero, e.dz);
            check_val("op_ready_done", op_ready, 0);
            $display("op ctrl=%0d a=0x%0h b=0x%0h -> res=0x%0h dz=%0b lat=%0d",
                     alu_ctrl, alu_a, alu_b, resultado, div_zero, lat);
        end
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            check_val("consumed_valid", res_valid, 0);
            check_val("consumed_ready", op_ready, 1);
            check_val("consumed_dz", div_zero, 0);
        end else begin
            res_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c,
                          input bit early_rdy);
        do_accept(a, b, c);
        collect(1'b1, early_rdy);
    endtask

    logic [N-1:0] ta [15] = '{32'd5, 32'd3, 32'd1234, 32'd100, 32'h1234_5678, 32'd1,
                              32'h8000_0000, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555,
                              32'h0000_FFFF, 32'd100, 32'hFFFF_FFFF, 32'd7, 32'd100};
    logic [N-1:0] tb_ [15] = '{32'd9, 32'd10, 32'd5678, 32'd7, 32'd0, 32'd31,
                               32'd4, 32'h0FF0_FF00, 32'h00F0_0010, 32'hFFFF_0000,
                               32'd0, 32'd7, 32'd1, 32'd100, 32'd7};
    logic [3:0]   tc [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4,
                              4'd5, 4'd6, 4'd7, 4'd8,
                              4'd9, 4'd11, 4'd3, 4'd3, 4'd10};

    initial begin
        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        ALUControl = '0; srcA = '0; srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_op_ready", op_ready, 1);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_resultado", resultado, 0);
        check_val("rst_div_zero", div_zero, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_alu_ctrl", alu_ctrl, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_op(ta[i], tb_[i], tc[i], 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [3:0]   c;
            logic [N-1:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 2 == 0) ? N'($urandom_range(0, 1000)) : $urandom;
            run_op(a, b, c, i[0]);
        end

        // Backpressure: result held while a new op waits on op_valid.
        do_accept(32'd20, 32'd22, 4'd0);
        collect(1'b0, 1'b0);
        @(negedge clk);
        srcA = 32'd3; srcB = 32'd4; ALUControl = 4'd1; op_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_val("bp_resultado", resultado, 42);
            check_val("bp_op_ready", op_ready, 0);
            check_val("bp_res_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_val("bp_consume_valid", res_valid, 0);
        check_val("bp_consume_ready", op_ready, 1);
        sb.push_back(ref_model(32'd3, 32'd4, 4'd1));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check_val("bp_new_busy", busy, 1);
        check_val("bp_new_alu_a", alu_a, 3);
        collect(1'b1, 1'b0);

        // Reset five cycles into a DIV abandons it.
        do_accept(32'd100, 32'd7, 4'd3);
        void'(sb.pop_back());
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("mid_rst_op_ready", op_ready, 1);
        check_val("mid_rst_res_valid", res_valid, 0);
        check_val("mid_rst_resultado", resultado, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_alu_a", alu_a, 0);

        run_op(32'd5, 32'd9, 4'd0, 1'b0);
        run_op(32'd100, 32'd7, 4'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
